// File: rtl/add_sub_pkg.sv
// -----------------------------------------------------------------------------
// add_sub_pkg
// Shared definitions for the bit-serial adder/subtractor.
//   state_t  : controller states IDLE / RUN / DONE
//   MODE_SUB : mode value selecting a - b
//   MODE_ADD : mode value selecting a + b
// -----------------------------------------------------------------------------
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/fas_cell.sv
// -----------------------------------------------------------------------------
// fas_cell
// Combinational 1-bit full adder / full subtractor.
// Ports:
//   x    : in  - bit of a (first addend / minuend)
//   y    : in  - bit of b (second addend / subtrahend)
//   cin  : in  - carry in (add) or borrow in (subtract)
//   mode : in  - MODE_ADD or MODE_SUB
//   s    : out - sum / difference bit
//   cout : out - carry out (add) or borrow out (subtract)
// -----------------------------------------------------------------------------
module fas_cell
  import add_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic mode,
  output logic s,
  output logic cout
);

  // The sum and difference bits are the same parity function; only the
  // carry/borrow generation differs. A borrow is produced when y plus the
  // incoming borrow exceeds x.
  always_comb begin
    s = x ^ y ^ cin;
    if (mode == MODE_ADD) begin
      cout = (x & y) | (cin & (x ^ y));
    end else begin
      cout = (~x & y) | (cin & ~(x ^ y));
    end
  end

endmodule

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single
// fas_cell. A request is accepted in IDLE, WIDTH cycles later the result is
// presented in DONE and held until the consumer takes it.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start_valid  : in  - request to start an operation
//   start_ready  : out - high only in IDLE
//   mode         : in  - 0 = a - b, 1 = a + b
//   a, b         : in  - operands (sampled only on the accepting edge)
//   res_valid    : out - high only in DONE
//   res_ready    : in  - consumer accepts the result
//   result       : out - sum / difference modulo 2^WIDTH
//   borrow       : out - subtract: a < b unsigned; add: carry out
//   ovf          : out - two's-complement overflow
//   busy         : out - high in RUN and DONE
// -----------------------------------------------------------------------------
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             ovf,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_mode;
  logic             r_carry;
  logic             r_borrow;
  logic             r_ovf;
  logic             r_start_ready;
  logic             r_res_valid;
  logic             r_busy;

  logic             w_sum;
  logic             w_cout;

  // The operand registers shift right each RUN cycle, so the cell always
  // sees the current bit in position 0.
  fas_cell u_cell (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .cin  (r_carry),
    .mode (r_mode),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Controller and datapath. Handshake flags are registered alongside the
  // state so they change on exactly the same edge as the state they mirror.
  // result/borrow/ovf are left untouched in IDLE so the last answer stays
  // visible until the next request starts overwriting result bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_result      <= '0;
      r_cnt         <= '0;
      r_mode        <= MODE_SUB;
      r_carry       <= 1'b0;
      r_borrow      <= 1'b0;
      r_ovf         <= 1'b0;
      r_start_ready <= 1'b1;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid && r_start_ready) begin
            r_a           <= a;
            r_b           <= b;
            r_mode        <= mode;
            r_carry       <= 1'b0;
            r_cnt         <= '0;
            r_state       <= RUN;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end

        RUN: begin
          r_result[r_cnt] <= w_sum;
          r_carry         <= w_cout;
          r_a             <= r_a >> 1;
          r_b             <= r_b >> 1;
          if (r_cnt == LAST_BIT) begin
            // r_carry still holds the carry into the MSB here; comparing it
            // with the carry out of the MSB gives signed overflow for both
            // add and subtract.
            r_borrow    <= w_cout;
            r_ovf       <= r_carry ^ w_cout;
            r_state     <= DONE;
            r_res_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        DONE: begin
          if (res_ready) begin
            r_state       <= IDLE;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end

        default: begin
          r_state       <= IDLE;
          r_res_valid   <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign res_valid   = r_res_valid;
  assign busy        = r_busy;
  assign result      = r_result;
  assign borrow      = r_borrow;
  assign ovf         = r_ovf;

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: start_valid  input  1  request to start an operation.
REQ-005 SHALL have port: start_ready  output  1  block can accept a request.
REQ-006 SHALL have port: mode  input  1  operation select, 0 = subtract (a-b), 1 = add (a+b).
REQ-007 SHALL have port: a  input  WIDTH  minuend / first addend.
REQ-008 SHALL have port: b  input  WIDTH  subtrahend / second addend.
REQ-009 SHALL have port: res_valid  output  1  result fields valid.
REQ-010 SHALL have port: res_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: result  output  WIDTH  difference or sum, modulo 2^WIDTH.
REQ-012 SHALL have port: borrow  output  1  subtract: 1 iff a<b unsigned; add: carry-out.
REQ-013 SHALL have port: ovf  output  1  two's-complement signed overflow of the operation.
REQ-014 SHALL have port: busy  output  1  high in RUN and DONE states.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; start_ready=1 only in IDLE; res_valid=1 only in DONE.
REQ-016 SHALL, on a rising edge with start_valid&&start_ready, capture a, b, mode, clear the carry/borrow register and bit counter to 0, and enter RUN.
REQ-017 SHALL, in RUN, process one bit per cycle LSB first through a 1-bit full add/sub cell, writing result bit[cnt] and updating the carry/borrow register.
REQ-018 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1; res_valid rises exactly WIDTH cycles after the accepting edge.
REQ-019 SHALL set borrow to the final carry/borrow register value and ovf to (carry-into-MSB XOR carry/borrow-out-of-MSB) on entering DONE.
REQ-020 SHALL hold result, borrow, ovf stable while res_valid=1 and res_ready=0 (indefinite backpressure).
REQ-021 SHALL return to IDLE on the edge where res_valid&&res_ready; no request is accepted in that same cycle.
REQ-022 SHALL ignore changes on a, b, mode, start_valid while busy=1.
REQ-023 SHALL keep result, borrow, ovf at their last DONE values while in IDLE until a new request is accepted.

Reset
REQ-024 SHALL, on rst asserted at any time including mid-RUN, immediately force state IDLE, counter 0, carry/borrow 0, result 0, borrow 0, ovf 0, res_valid 0, busy 0, start_ready 1.
REQ-025 SHALL accept a new request on the first rising edge after rst deasserts.

Structure
REQ-026 SHALL place the FSM state typedef (IDLE/RUN/DONE) and mode constants (MODE_SUB=0, MODE_ADD=1) in shared package add_sub_pkg.
REQ-027 SHALL instantiate one sub-module fas_cell (inputs x, y, cin, mode; outputs s, cout) as the combinational 1-bit full adder/subtractor.
REQ-028 SHALL use a counter of width $clog2(WIDTH) and operand shift registers; no WIDTH-bit combinational adder.

Verification (WIDTH=8)
REQ-029 SHALL cover: sub a=0x05 b=0x03 -> result 0x02, borrow 0, ovf 0, res_valid 8 cycles after accept.
REQ-030 SHALL cover: sub a=0x03 b=0x05 -> 0xFE, borrow 1, ovf 0; sub a=0x80 b=0x01 -> 0x7F, borrow 0, ovf 1.
REQ-031 SHALL cover: add a=0xFF b=0x01 -> 0x00, borrow(carry) 1, ovf 0; add a=0x7F b=0x01 -> 0x80, carry 0, ovf 1.
REQ-032 SHALL cover: res_ready held 0 for 5 cycles in DONE with a/b toggling -> outputs stable, start_ready 0, single completion.
REQ-033 SHALL cover: rst pulsed after bit 3 processed -> all outputs 0 and start_ready 1 immediately; next request add 0x10+0x22 -> 0x32.
REQ-034 SHALL cover: back-to-back requests with start_valid held high -> second accepted one cycle after first handshake completes.
